// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encoding and MD counter sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_BUSY  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } stall_state_e;

   // Wide enough to hold DIV_LAT-1 with one spare bit.
   function automatic int md_cnt_width(input int div_lat);
      return $clog2(div_lat) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_lat_counter.sv
// ============================================================================
// md_lat_counter : load/decrement/hold occupancy counter with last-cycle flag
// Rev 1.0
// ============================================================================
`default_nettype none

module md_lat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = md_cnt_width(32)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl : merges mem-wait, MUL/DIV occupancy, load-use and branch
// flush into per-stage write/flush enables. Optional: STALL_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_hazard_i,
   input  logic             branch_taken_i,
   input  logic             md_start_i,
   input  logic             md_is_div_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             idex_write_o,
   output logic             exmem_write_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic             memwb_flush_o,
   output logic             md_done_o,
`ifdef STALL_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_cnt_o,
`endif
   output logic [1:0]       state_o
);

   localparam int             MD_W       = md_cnt_width(DIV_LAT);
   localparam logic [MD_W-1:0] c_mul_load = MD_W'(MUL_LAT - 1);
   localparam logic [MD_W-1:0] c_div_load = MD_W'(DIV_LAT - 1);

   if ((CNT_W < 1) || (MUL_LAT < 2) || (DIV_LAT < MUL_LAT)) begin : g_bad_param
      $error("pipeline_stall_ctrl: illegal parameter combination");
   end

   stall_state_e state_q, state_d;
   stall_state_e ret_q, ret_d;
   stall_state_e w_eff_state;
   logic         w_mem_stall;
   logic         w_md_load;
   logic         w_md_dec;
   logic         w_md_last;

   assign w_mem_stall = mem_req_i & ~mem_ready_i;

   md_lat_counter #(
      .CNT_W (MD_W)
   ) u_md_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_md_load),
      .load_val_i (md_is_div_i ? c_div_load : c_mul_load),
      .dec_i      (w_md_dec),
      .last_o     (w_md_last)
   );

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_write_o  = 1'b1;
      exmem_write_o = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      memwb_flush_o = 1'b0;
      md_done_o     = 1'b0;
      state_d       = ST_RUN;
      ret_d         = ret_q;
      w_md_load     = 1'b0;
      w_md_dec      = 1'b0;
      // Leaving MEM_WAIT, the cycle behaves as the state that was interrupted.
      w_eff_state   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

      if (w_mem_stall) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_write_o  = 1'b0;
         exmem_write_o = 1'b0;
         memwb_flush_o = 1'b1;
         state_d       = ST_MEM_WAIT;
         if (state_q != ST_MEM_WAIT) begin
            ret_d = (state_q == ST_MD_BUSY) ? ST_MD_BUSY : ST_RUN;
         end
      end else begin
         case (w_eff_state)
            ST_RUN: begin
               if (md_start_i) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_write_o  = 1'b0;
                  exmem_flush_o = 1'b1;
                  w_md_load     = 1'b1;
                  state_d       = ST_MD_BUSY;
               end else if (load_hazard_i) begin
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  idex_flush_o = 1'b1;
               end else if (branch_taken_i) begin
                  ifid_flush_o = 1'b1;
               end
            end
            ST_MD_BUSY: begin
               w_md_dec = 1'b1;
               if (w_md_last) begin
                  md_done_o = 1'b1;
               end else begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_write_o  = 1'b0;
                  exmem_flush_o = 1'b1;
                  state_d       = ST_MD_BUSY;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end

      if (!rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_write_o  = 1'b0;
         exmem_write_o = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
         memwb_flush_o = 1'b1;
         md_done_o     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
      end
   end

   assign state_o = rst_i ? state_q : ST_RUN;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// tb_pipeline_stall_ctrl : directed vectors, expected outputs queued per cycle
// and checked by an independent negedge monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

   // Output vector: {pc,ifid,idex,exmem, ifid_f,idex_f,exmem_f,memwb_f, done, state[1:0]}
   localparam logic [10:0] E_RST  = 11'b1111_0000_0_00 ^ 11'b1111_1111_0_00;
   localparam logic [10:0] E_IDLE = 11'b1111_0000_0_00;
   localparam logic [10:0] E_LU   = 11'b0011_0100_0_00;
   localparam logic [10:0] E_BR   = 11'b1111_1000_0_00;
   localparam logic [10:0] E_MDS  = 11'b0001_0010_0_00;
   localparam logic [10:0] E_MDB  = 11'b0001_0010_0_01;
   localparam logic [10:0] E_MDD  = 11'b1111_0000_1_01;
   localparam logic [10:0] E_MST0 = 11'b0000_0001_0_00;
   localparam logic [10:0] E_MST1 = 11'b0000_0001_0_01;
   localparam logic [10:0] E_MW   = 11'b0000_0001_0_10;
   localparam logic [10:0] E_MDW  = 11'b0001_0010_0_10;
   localparam logic [10:0] E_BRW  = 11'b1111_1000_0_10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic lh = 1'b0, br = 1'b0, ms = 1'b0, dv = 1'b0, mreq = 1'b0, mrdy = 1'b0;
   logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, done;
   logic [1:0] st;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [10:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .MUL_LAT (4),
      .DIV_LAT (32),
      .CNT_W   (32)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_n),
      .load_hazard_i  (lh),
      .branch_taken_i (br),
      .md_start_i     (ms),
      .md_is_div_i    (dv),
      .mem_req_i      (mreq),
      .mem_ready_i    (mrdy),
      .pc_write_o     (pc_w),
      .ifid_write_o   (ifid_w),
      .idex_write_o   (idex_w),
      .exmem_write_o  (exmem_w),
      .ifid_flush_o   (ifid_f),
      .idex_flush_o   (idex_f),
      .exmem_flush_o  (exmem_f),
      .memwb_flush_o  (memwb_f),
      .md_done_o      (done),
`ifdef STALL_PERF_CNT_EN
      .stall_cycles_o (stall_cycles),
      .flush_cnt_o    (flush_cnt),
`endif
      .state_o        (st)
   );

   // Inputs vector: {load_hazard, branch, md_start, md_is_div, mem_req, mem_ready}
   task automatic step(input logic [5:0] in, input logic rst, input logic [10:0] e,
                       input string nm);
      @(posedge clk);
      #1;
      {lh, br, ms, dv, mreq, mrdy} = in;
      rst_n = rst;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) step(6'b000000, 1'b1, E_IDLE, nm);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [10:0] got;
         logic [10:0] e;
         string       nm;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, done, st};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %b required %b", nm, $time, got, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(6'b000000, 1'b0, E_RST, "reset0");
      step(6'b000000, 1'b0, E_RST, "reset1");
      idle(2, "idle_after_reset");

      // Load-use for one cycle, then load-use masking a branch, then branch alone
      step(6'b100000, 1'b1, E_LU,   "load_use");
      idle(1, "load_use_clear");
      step(6'b110000, 1'b1, E_LU,   "load_use_over_branch");
      step(6'b010000, 1'b1, E_BR,   "branch_alone");
      idle(1, "branch_clear");

      // Multiply: hazards during occupancy must be ignored
      step(6'b001000, 1'b1, E_MDS,  "mul_start");
      step(6'b100000, 1'b1, E_MDB,  "mul_busy1_lu_ignored");
      step(6'b010000, 1'b1, E_MDB,  "mul_busy2_br_ignored");
      step(6'b000000, 1'b1, E_MDD,  "mul_done");
      idle(1, "mul_after");

      // Divide with a 3-cycle memory stall at T+5..T+7, done expected at T+34
      step(6'b001100, 1'b1, E_MDS,  "div_start");
      for (int i = 1; i <= 4; i++) step(6'b000000, 1'b1, E_MDB, "div_busy_pre");
      step(6'b000010, 1'b1, E_MST1, "div_mem_stall_enter");
      step(6'b000010, 1'b1, E_MW,   "div_mem_wait1");
      step(6'b000010, 1'b1, E_MW,   "div_mem_wait2");
      step(6'b000011, 1'b1, E_MDW,  "div_mem_release");
      for (int i = 9; i <= 33; i++) step(6'b000000, 1'b1, E_MDB, "div_busy_post");
      step(6'b000000, 1'b1, E_MDD,  "div_done_T34");
      idle(1, "div_after");

      // Memory stall from RUN beats load-use; branch honoured on the release cycle
      step(6'b100010, 1'b1, E_MST0, "run_mem_stall_over_lu");
      step(6'b000010, 1'b1, E_MW,   "run_mem_wait");
      step(6'b010011, 1'b1, E_BRW,  "run_mem_release_branch");
      idle(1, "run_mem_after");

      // Asynchronous reset in the middle of a divide aborts without md_done
      step(6'b001100, 1'b1, E_MDS,  "div2_start");
      step(6'b000000, 1'b1, E_MDB,  "div2_busy");
      step(6'b000000, 1'b0, E_RST,  "div2_async_reset");
      step(6'b000000, 1'b0, E_RST,  "div2_reset_hold");
      idle(36, "post_reset_no_done");

`ifdef STALL_PERF_CNT_EN
      step(6'b001000, 1'b1, E_MDS,  "perf_mul_start");
      step(6'b000000, 1'b1, E_MDB,  "perf_mul_busy1");
      step(6'b000000, 1'b1, E_MDB,  "perf_mul_busy2");
      step(6'b000000, 1'b1, E_MDD,  "perf_mul_done");
      step(6'b100000, 1'b1, E_LU,   "perf_load_use");
      idle(1, "perf_idle");
      @(negedge clk);
      n_cmp++;
      if (stall_cycles !== 32'd4) begin
         n_err++;
         $display("FAIL perf_stall_cycles: got %0d required 4", stall_cycles);
      end
      n_cmp++;
      if (flush_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL perf_flush_cnt: got %0d required 0", flush_cnt);
      end
`endif

      repeat (3) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
